// File: rtl/des_key_schedule_if.sv
// Handshake bundle between the DES key schedule and its driver/consumer.
// The schedule side uses the slave modport; the key source / round function side uses master.
interface des_key_schedule_if;
  logic        start;
  logic        decrypt;
  logic [0:63] key;
  logic        advance;
  logic [0:47] subkey;
  logic [3:0]  kidx;
  logic        valid;
  logic        busy;
  logic        done;
  logic        parity_err;

  modport master (
    output start, decrypt, key, advance,
    input  subkey, kidx, valid, busy, done, parity_err
  );

  modport slave (
    input  start, decrypt, key, advance,
    output subkey, kidx, valid, busy, done, parity_err
  );
endinterface

// File: rtl/des_key_schedule.sv
// Sequential DES key schedule: PC-1 once, then one PC-2 subkey per accepted handshake.
// Optional macro DES_KEY_PARITY_CHECK_EN rejects keys with an even-parity byte.
module des_key_schedule (
  input  logic              clk,
  input  logic              rst,
  des_key_schedule_if.slave bus
);
  typedef enum logic {IDLE, RUN} state_t;

  // FIPS 46-3 tables, 1-based bit numbers
  localparam int PC1 [0:55] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [0:47] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  function automatic logic [0:55] pc1(input logic [0:63] k);
    logic [0:55] r;
    r = '0;
    for (int i = 0; i < 56; i++) r[6'(i)] = k[6'(PC1[6'(i)] - 1)];
    return r;
  endfunction

  function automatic logic [0:47] pc2(input logic [0:55] cd);
    logic [0:47] r;
    r = '0;
    for (int i = 0; i < 48; i++) r[6'(i)] = cd[6'(PC2[6'(i)] - 1)];
    return r;
  endfunction

  function automatic logic [0:27] rotl(input logic [0:27] x, input logic two);
    return two ? {x[2:27], x[0:1]} : {x[1:27], x[0]};
  endfunction

  function automatic logic [0:27] rotr(input logic [0:27] x, input logic two);
    return two ? {x[26:27], x[0:25]} : {x[27], x[0:26]};
  endfunction

  // Rounds 1, 2, 9 and 16 shift by one; all others by two.
  function automatic logic shift_two(input logic [4:0] round);
    return !(round == 5'd1 || round == 5'd2 || round == 5'd9 || round == 5'd16);
  endfunction

  function automatic logic key_parity_ok(input logic [0:63] k);
    return &{^k[0:7], ^k[8:15], ^k[16:23], ^k[24:31],
             ^k[32:39], ^k[40:47], ^k[48:55], ^k[56:63]};
  endfunction

  state_t      state, state_nxt;
  logic [0:27] c_q, d_q, c_nxt, d_nxt;
  logic [3:0]  rc_q, rc_nxt;
  logic        dir_q, dir_nxt;
  logic        done_q, done_nxt;
  logic        perr_q, perr_nxt;
  logic        key_ok;
  logic [0:55] cd_load;
  logic [4:0]  enc_round, dec_round;

`ifdef DES_KEY_PARITY_CHECK_EN
  assign key_ok = key_parity_ok(bus.key);
`else
  assign key_ok = 1'b1;
`endif

  assign cd_load   = pc1(bus.key);
  assign enc_round = 5'd2 + {1'b0, rc_q};
  assign dec_round = 5'd16 - {1'b0, rc_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      c_q    <= '0;
      d_q    <= '0;
      rc_q   <= '0;
      dir_q  <= 1'b0;
      done_q <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      c_q    <= c_nxt;
      d_q    <= d_nxt;
      rc_q   <= rc_nxt;
      dir_q  <= dir_nxt;
      done_q <= done_nxt;
      perr_q <= perr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    c_nxt     = c_q;
    d_nxt     = d_q;
    rc_nxt    = rc_q;
    dir_nxt   = dir_q;
    done_nxt  = 1'b0;
    perr_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (key_ok) begin
            // C16/D16 equal C0/D0, so decrypt starts from the unrotated halves.
            c_nxt     = bus.decrypt ? cd_load[0:27]  : rotl(cd_load[0:27], 1'b0);
            d_nxt     = bus.decrypt ? cd_load[28:55] : rotl(cd_load[28:55], 1'b0);
            dir_nxt   = bus.decrypt;
            rc_nxt    = 4'd0;
            state_nxt = RUN;
          end else begin
            perr_nxt = 1'b1;
          end
        end
      end
      RUN: begin
        if (bus.advance) begin
          rc_nxt = rc_q + 4'd1;
          if (rc_q == 4'd15) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else if (dir_q) begin
            c_nxt = rotr(c_q, shift_two(dec_round));
            d_nxt = rotr(d_q, shift_two(dec_round));
          end else begin
            c_nxt = rotl(c_q, shift_two(enc_round));
            d_nxt = rotl(d_q, shift_two(enc_round));
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.valid      = (state == RUN);
  assign bus.busy       = (state == RUN);
  assign bus.done       = done_q;
  assign bus.parity_err = perr_q;
  assign bus.kidx       = (state == RUN) ? (dir_q ? 4'd15 - rc_q : rc_q) : 4'd0;
  assign bus.subkey     = pc2({c_q, d_q});
endmodule

// File: tb/tb_des_key_schedule.sv
// Directed bench for des_key_schedule using the 133457799BBCDFF1 key schedule table.
module tb_des_key_schedule;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  des_key_schedule_if bus ();
  des_key_schedule dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic        dec;
    logic [63:0] key;
    logic [3:0]  kidx;
    logic [47:0] sk;
  } vec_t;

  localparam logic [63:0] GOOD_KEY = 64'h133457799BBCDFF1;
  localparam logic [63:0] BAD_KEY  = 64'h123457799BBCDFF1;

  logic [47:0] ks [16];
  vec_t        vecs [32];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " valid"},  48'(bus.valid), 48'd0);
    check({tag, " busy"},   48'(bus.busy), 48'd0);
    check({tag, " kidx"},   48'(bus.kidx), 48'd0);
    check({tag, " perr"},   48'(bus.parity_err), 48'd0);
  endtask

  task automatic check_step(input int v, input string tag);
    check({tag, " valid"},  48'(bus.valid), 48'd1);
    check({tag, " busy"},   48'(bus.busy), 48'd1);
    check({tag, " perr"},   48'(bus.parity_err), 48'd0);
    check({tag, " kidx"},   48'(bus.kidx), 48'(vecs[v].kidx));
    check({tag, " subkey"}, bus.subkey, vecs[v].sk);
  endtask

  // Full schedule with advance held high; returns in the done cycle.
  task automatic run_sched(input int base, input string tag);
    bus.decrypt = vecs[base].dec;
    bus.key     = vecs[base].key;
    bus.start   = 1'b1;
    bus.advance = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check_step(base + i, tag);
      tick();
    end
    check({tag, " done"},      48'(bus.done), 48'd1);
    check({tag, " busy end"},  48'(bus.busy), 48'd0);
    check({tag, " valid end"}, 48'(bus.valid), 48'd0);
  endtask

  initial begin
    ks = '{48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
           48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
           48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
           48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5};
    for (int i = 0; i < 16; i++) begin
      vecs[i]      = '{dec: 1'b0, key: GOOD_KEY, kidx: 4'(i),      sk: ks[i]};
      vecs[16 + i] = '{dec: 1'b1, key: GOOD_KEY, kidx: 4'(15 - i), sk: ks[15 - i]};
    end

    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.decrypt = 1'b0;
    bus.key     = '0;
    bus.advance = 1'b0;
    tick();
    tick();
    check_idle_outputs("reset");
    check("reset done",   48'(bus.done), 48'd0);
    check("reset subkey", bus.subkey, 48'd0);
    rst = 1'b0;
    tick();
    bus.advance = 1'b1;
    tick();
    bus.advance = 1'b0;
    tick();
    check_idle_outputs("idle adv");
    check("idle adv subkey", bus.subkey, 48'd0);
    check("idle adv done",   48'(bus.done), 48'd0);

    // Encrypt, then decrypt started in the done cycle.
    run_sched(0, "enc");
    run_sched(16, "dec");
    bus.advance = 1'b0;
    tick();
    check("dec done clear", 48'(bus.done), 48'd0);
    check("dec idle valid", 48'(bus.valid), 48'd0);

    // Stall at kidx 5 with a stray start and flipped decrypt.
    bus.decrypt = 1'b0;
    bus.key     = GOOD_KEY;
    bus.start   = 1'b1;
    bus.advance = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check_step(i, "stall");
      if (i == 5) begin
        bus.advance = 1'b0;
        bus.start   = 1'b1;
        bus.decrypt = 1'b1;
        bus.key     = BAD_KEY;
        for (int s = 0; s < 3; s++) begin
          tick();
          check_step(5, "stall hold");
        end
        bus.start   = 1'b0;
        bus.advance = 1'b1;
      end
      tick();
    end
    check("stall done", 48'(bus.done), 48'd1);
    bus.advance = 1'b0;
    tick();
    check("stall done clear", 48'(bus.done), 48'd0);

    // Reset in the middle of a schedule.
    bus.decrypt = 1'b0;
    bus.key     = GOOD_KEY;
    bus.start   = 1'b1;
    bus.advance = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      check_step(i, "prerst");
      if (i < 8) tick();
    end
    rst = 1'b1;
    #1;
    check_idle_outputs("midrst");
    check("midrst subkey", bus.subkey, 48'd0);
    tick();
    check("midrst done", 48'(bus.done), 48'd0);
    rst = 1'b0;
    tick();
    check("postrst done", 48'(bus.done), 48'd0);
    check_idle_outputs("postrst");
    run_sched(0, "rerun");
    bus.advance = 1'b0;
    tick();

    // Key with an even-parity first byte.
    bus.decrypt = 1'b0;
    bus.key     = BAD_KEY;
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
`ifdef DES_KEY_PARITY_CHECK_EN
    check("bad key perr",  48'(bus.parity_err), 48'd1);
    check("bad key valid", 48'(bus.valid), 48'd0);
    tick();
    check("bad key perr clear", 48'(bus.parity_err), 48'd0);
    check("bad key still idle", 48'(bus.valid), 48'd0);
`else
    check("bad key perr",  48'(bus.parity_err), 48'd0);
    check("bad key valid", 48'(bus.valid), 48'd1);
    bus.advance = 1'b1;
    for (int i = 0; i < 16; i++) tick();
    check("bad key done", 48'(bus.done), 48'd1);
    bus.advance = 1'b0;
    tick();
`endif
    run_sched(0, "good key");
    bus.advance = 1'b0;
    tick();
    check("final perr", 48'(bus.parity_err), 48'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/des_key_schedule.md
# des_key_schedule

Sequential DES key-schedule generator that sits directly upstream of the round function `des_function`. It applies PC-1 to a 64-bit key once, then issues the sixteen 48-bit round subkeys one per accepted handshake. Each subkey is produced by PC-2 on the rotating C/D halves and goes onto the round function's `key` input. Encrypt order is K1..K16; decrypt order is K16..K1, produced by right rotations with no stored key table.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a new schedule; sampled only in IDLE.
- `decrypt`  in  1  sampled with `start`:
  - 0 = encrypt order K1..K16.
  - 1 = decrypt order K16..K1.
- `key`  in  [0:63]  DES key; bit 0 is the DES MSB (bit 1 in FIPS numbering); parity bits are ignored by PC-1.
- `advance`  in  1  consumer accepts the current subkey.
- `subkey`  out  [0:47]  current round key, PC-2(C,D), same bit order as the round function's `key`.
- `kidx`  out  [3:0]  subkey number minus 1 (K1 = 0, K16 = 15).
- `valid`  out  1  `subkey` / `kidx` are meaningful.
- `busy`  out  1  schedule in progress.
- `done`  out  1  one-cycle pulse after the 16th subkey is accepted.
- `parity_err`  out  1  see Configuration.

## Operation
- State: 28-bit registers C and D, 4-bit round counter `rc`, direction flag, FSM {IDLE, RUN}.
- Shift schedule by round 1..16: 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- IDLE plus `start`, on the next edge:
  - {C,D} loads from PC-1(key).
  - Encrypt: C and D are also rotated left by 1, giving C1/D1.
  - Decrypt: C and D load unrotated, since C16/D16 equal C0/D0.
  - `rc` loads 0; FSM goes to RUN.
- RUN:
  - `valid` = 1 and `subkey` = PC-2(C,D), combinational from the registers.
  - Encrypt: `kidx` = `rc`. Decrypt: `kidx` = 15 − `rc`.
- Handshake: a transfer occurs on a cycle with `valid` && `advance`.
  - Encrypt: C and D rotate left by shift[`rc`+2].
  - Decrypt: C and D rotate right by shift[16 − `rc`].
  - `rc` increments by 1.
- Transfer with `rc` = 15: FSM returns to IDLE and `done` pulses on the following cycle. No further rotation is needed or required.
- `advance` while `valid` = 0 is ignored.
- `start` while in RUN is ignored; `key` and `decrypt` are not re-sampled.
- Rotations are modulo 28 within each half. C and D never mix.

## Timing
- Reset values: FSM = IDLE, C = D = 0, `rc` = 0.
- Reset outputs:
  - `valid`, `busy`, `done`, `parity_err` = 0.
  - `kidx` = 0.
  - `subkey` = PC-2(0) = 0.
- Latency: `start` sampled at edge t gives `valid` = 1 with the first subkey from t+1.
- Throughput: one subkey per cycle with `advance` held high. A full schedule takes 16 cycles of `valid` plus 1 load cycle.
- `busy` = 1 from the load edge until the edge that accepts the 16th subkey.
- `done` is high exactly one cycle, in the first IDLE cycle. `start` asserted in that cycle is accepted.
- Back-to-back schedules: the minimum gap from the final `advance` to the next first `valid` is 2 cycles.
- Reset asserted mid-schedule immediately forces all reset values. No `done` pulse is produced.
- `subkey` is held stable while `valid` && !`advance`.

## Configuration
Macro: `DES_KEY_PARITY_CHECK_EN`.
- Defined:
  - In IDLE with `start`, each key byte is checked for odd parity.
  - If any byte has even parity, `parity_err` is set for exactly one cycle (the cycle after `start`) and the FSM stays in IDLE: no load, `valid` stays 0.
  - Otherwise the schedule proceeds normally.
- Undefined:
  - No check is performed and `parity_err` is tied to 0.
  - Port list is unchanged.

## Test plan
- Reset, then idle with `start` = 0: all outputs at reset values. `advance` pulses change nothing.
- Encrypt, `key` = 133457799BBCDFF1, `advance` held high:
  - cycle t+1: `subkey` = 1B02EFFC7072 with `kidx` = 0.
  - next cycle: 79AED9DBC9E5 with `kidx` = 1.
  - 16th: CB3D8B0E17F5 with `kidx` = 15.
  - then `done` = 1 for one cycle and `busy` = 0.
- Decrypt, same key: first `subkey` = CB3D8B0E17F5 with `kidx` = 15; last = 1B02EFFC7072 with `kidx` = 0. All 16 values equal the encrypt run reversed.
- Stall: drop `advance` for 3 cycles at `kidx` = 5. `subkey` and `kidx` are held. Resuming continues with `kidx` = 6 and the correct value. A `start` during the stall is ignored.
- Reset asserted at `kidx` = 8: next cycle `valid` = 0 and `busy` = 0. A new `start` gives K1 again.
- With `DES_KEY_PARITY_CHECK_EN`:
  - `key` = 123457799BBCDFF1 → `parity_err` pulses and `valid` stays 0.
  - `key` = 133457799BBCDFF1 → normal run with no `parity_err`.
